// File: rtl/ot_keccak_run_arb_pkg.sv
// ot_keccak_arb_pkg
// Shared types and constants for the Keccak run-request arbiter.
//   arb_st_e          : 6-bit sparse FSM encodings, pairwise Hamming distance 4
//   ArbStateW         : width of the FSM state register
//   lc_tx_t, On, Off  : life-cycle multi-bit signal and its two valid values
//   lc_tx_test_true_loose : any value other than Off counts as asserted
//   MaxHoldDefault, WdogWDefault : watchdog defaults
package ot_keccak_arb_pkg;

  localparam int ArbStateW      = 6;
  localparam int MaxHoldDefault = 1000;
  localparam int WdogWDefault   = 16;

  // Every pair of encodings differs in 4 bits, so a single or double bit
  // flip always lands on an invalid code and is caught as a fault.
  typedef enum logic [ArbStateW-1:0] {
    StIdle          = 6'b001011,
    StActive        = 6'b110001,
    StTerminalError = 6'b010110
  } arb_st_e;

  typedef logic [3:0] lc_tx_t;
  localparam lc_tx_t On  = 4'b0101;
  localparam lc_tx_t Off = 4'b1010;

  // Loose test: a corrupted value is treated as an escalation.
  function automatic logic lc_tx_test_true_loose(lc_tx_t val);
    return val != Off;
  endfunction

endpackage

// File: rtl/ot_keccak_run_arb_if.sv
// ot_keccak_run_arb_if
// Run request/acknowledge bundle between the Keccak cores and the arbiter.
//   req : one request bit per core, held until the permutation completes
//   ack : one registered grant bit per core
// Modports: master = core side (drives req), slave = arbiter side (drives ack).
interface ot_keccak_run_arb_if #(
  parameter int NumReq = 4
);
  logic [NumReq-1:0] req;
  logic [NumReq-1:0] ack;

  modport master (output req, input ack);
  modport slave  (input req, output ack);
endinterface

// File: rtl/ot_keccak_run_arb_rr_pick.sv
// ot_keccak_arb_rr_pick
// Combinational round-robin picker: rotate the candidate vector so that bit
// ptr becomes bit 0, take the lowest set bit, then map back to an absolute index.
//   cand  : candidate bit per requester
//   ptr   : index with highest priority this cycle
//   valid : at least one candidate
//   idx   : winning requester index (0 when valid is low)
module ot_keccak_arb_rr_pick #(
  parameter int NumReq = 4
) (
  input  logic [NumReq-1:0]         cand,
  input  logic [$clog2(NumReq)-1:0] ptr,
  output logic                      valid,
  output logic [$clog2(NumReq)-1:0] idx
);
  localparam int IdxW = $clog2(NumReq);
  localparam logic [IdxW:0] NumReqW = (IdxW+1)'(NumReq);

  logic [2*NumReq-1:0] cand_dbl;
  logic [NumReq-1:0]   cand_rot;
  logic [IdxW-1:0]     off;
  logic [IdxW:0]       sum;
  logic                unused_hi;

  // Shifting a doubled copy gives a rotate that also works when NumReq is
  // not a power of two.
  assign cand_dbl  = {cand, cand} >> ptr;
  assign cand_rot  = cand_dbl[NumReq-1:0];
  assign unused_hi = ^cand_dbl[2*NumReq-1:NumReq];

  always_comb begin
    valid = 1'b0;
    off   = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      if (cand_rot[k]) begin
        valid = 1'b1;
        off   = IdxW'(k);
      end
    end
  end

  assign sum = {1'b0, off} + {1'b0, ptr};
  assign idx = (sum >= NumReqW) ? IdxW'(sum - NumReqW) : sum[IdxW-1:0];

endmodule

// File: rtl/ot_keccak_run_arb.sv
// ot_keccak_run_arb
// Grants the Keccak run request of up to MaxActive cores at a time so that
// cores sharing one power budget never all permute together.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   run (slave)         : req per core in, registered ack per core out
//   lc_escalate_en_i    : life-cycle escalation, drops all grants for good
//   active_cnt_o        : number of grants currently held
//   busy_o              : FSM is in StActive
//   sparse_fsm_error_o  : FSM in StTerminalError or in an invalid encoding
//   wdog_error_o        : sticky, a grant was held for MaxHold cycles
//   wdog_idx_o          : requester that tripped the watchdog
// Build option: define OT_KECCAK_RUN_ARB_WDOG_EN to add the per-requester
// hold watchdog; otherwise wdog_error_o and wdog_idx_o are tied to 0.
module ot_keccak_run_arb
  import ot_keccak_arb_pkg::*;
#(
  parameter int NumReq    = 4,
  parameter int MaxActive = 1,
  parameter int WdogW     = WdogWDefault,
  parameter int MaxHold   = MaxHoldDefault
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  ot_keccak_run_arb_if.slave          run,
  input  lc_tx_t                      lc_escalate_en_i,
  output logic [$clog2(NumReq+1)-1:0] active_cnt_o,
  output logic                        busy_o,
  output logic                        sparse_fsm_error_o,
  output logic                        wdog_error_o,
  output logic [$clog2(NumReq)-1:0]   wdog_idx_o
);
  localparam int IdxW = $clog2(NumReq);
  localparam int CntW = $clog2(NumReq + 1);

  function automatic logic [CntW-1:0] popcnt(logic [NumReq-1:0] vec);
    logic [CntW-1:0] cnt;
    cnt = '0;
    for (int k = 0; k < NumReq; k++) begin
      cnt = cnt + CntW'(vec[k]);
    end
    return cnt;
  endfunction

  arb_st_e           state_q, state_d;
  logic [NumReq-1:0] grant_q, grant_d;
  logic [NumReq-1:0] kept, cand;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic              pick_valid;
  logic [IdxW-1:0]   pick_idx;
  logic [CntW-1:0]   kept_cnt;
  logic              esc;
  logic              wdog_block;

  assign esc      = lc_tx_test_true_loose(lc_escalate_en_i);
  // Grants whose request just fell are excluded, so their slot is free now.
  assign kept     = grant_q & run.req;
  assign cand     = run.req & ~grant_q;
  assign kept_cnt = popcnt(kept);

  ot_keccak_arb_rr_pick #(
    .NumReq(NumReq)
  ) u_rr_pick (
    .cand (cand),
    .ptr  (rr_ptr_q),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = kept;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      StIdle, StActive: begin
        if (pick_valid && (kept_cnt < CntW'(MaxActive)) && !wdog_block) begin
          grant_d[pick_idx] = 1'b1;
          rr_ptr_d = (pick_idx == IdxW'(NumReq - 1)) ? '0 : pick_idx + 1'b1;
        end
        // Evaluated on the next grant vector so a release plus a new grant
        // in the same cycle keeps the FSM in StActive.
        state_d = (grant_d != '0) ? StActive : StIdle;
      end
      StTerminalError: begin
        grant_d = '0;
      end
      default: begin
        grant_d = '0;
        state_d = StTerminalError;
      end
    endcase
    if (esc) begin
      state_d  = StTerminalError;
      grant_d  = '0;
      rr_ptr_d = rr_ptr_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign run.ack            = grant_q;
  assign active_cnt_o       = popcnt(grant_q);
  assign busy_o             = (state_q == StActive);
  assign sparse_fsm_error_o = !((state_q == StIdle) || (state_q == StActive));

`ifdef OT_KECCAK_RUN_ARB_WDOG_EN
  logic [NumReq-1:0] trip;
  logic [IdxW-1:0]   trip_idx;
  logic              wdog_error_q;
  logic [IdxW-1:0]   wdog_idx_q;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_wdog
    logic [WdogW-1:0] hold_q;

    // Fires on the edge where the counter reaches MaxHold.
    assign trip[gi] = grant_q[gi] && (hold_q == WdogW'(MaxHold - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        hold_q <= '0;
      end else if (!grant_q[gi]) begin
        hold_q <= '0;
      end else if (hold_q != WdogW'(MaxHold)) begin
        hold_q <= hold_q + 1'b1;
      end
    end
  end

  always_comb begin
    trip_idx = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      if (trip[k]) begin
        trip_idx = IdxW'(k);
      end
    end
  end

  // The grant stays in place: revoking it would corrupt a permutation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdog_error_q <= 1'b0;
      wdog_idx_q   <= '0;
    end else if (!wdog_error_q && (trip != '0)) begin
      wdog_error_q <= 1'b1;
      wdog_idx_q   <= trip_idx;
    end
  end

  assign wdog_block   = wdog_error_q;
  assign wdog_error_o = wdog_error_q;
  assign wdog_idx_o   = wdog_idx_q;
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = (WdogW > 0) ^ (MaxHold > 0);
  assign wdog_block      = 1'b0;
  assign wdog_error_o    = 1'b0;
  assign wdog_idx_o      = '0;
`endif

  a_active_max: assert property (@(posedge clk_i) disable iff (rst_i)
    active_cnt_o <= CntW'(MaxActive));

endmodule

// File: tb/tb_ot_keccak_run_arb.sv
// tb_ot_keccak_run_arb
// Two arbiters (MaxActive=1 and MaxActive=2) driven by directed steps and
// random request traffic, compared every cycle against a queue-free
// behavioural model of the grant rules.
module tb_ot_keccak_run_arb;
  import ot_keccak_arb_pkg::*;

  localparam int N   = 4;
  localparam int MhA = 8;
  localparam int MhB = 1000;
`ifdef OT_KECCAK_RUN_ARB_WDOG_EN
  localparam bit WdogOn = 1'b1;
`else
  localparam bit WdogOn = 1'b0;
`endif

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  lc_tx_t lc_a = Off;
  lc_tx_t lc_b = Off;

  ot_keccak_run_arb_if #(.NumReq(N)) run_a ();
  ot_keccak_run_arb_if #(.NumReq(N)) run_b ();

  logic [2:0] cnt_a, cnt_b;
  logic       busy_a, busy_b, ferr_a, ferr_b, werr_a, werr_b;
  logic [1:0] widx_a, widx_b;

  ot_keccak_run_arb #(.NumReq(N), .MaxActive(1), .WdogW(16), .MaxHold(MhA)) dut_a (
    .clk_i(clk), .rst_i(rst), .run(run_a), .lc_escalate_en_i(lc_a),
    .active_cnt_o(cnt_a), .busy_o(busy_a), .sparse_fsm_error_o(ferr_a),
    .wdog_error_o(werr_a), .wdog_idx_o(widx_a));

  ot_keccak_run_arb #(.NumReq(N), .MaxActive(2), .WdogW(16), .MaxHold(MhB)) dut_b (
    .clk_i(clk), .rst_i(rst), .run(run_b), .lc_escalate_en_i(lc_b),
    .active_cnt_o(cnt_b), .busy_o(busy_b), .sparse_fsm_error_o(ferr_b),
    .wdog_error_o(werr_b), .wdog_idx_o(widx_b));

  always #5 clk = ~clk;

  // Reference model state, one slot per DUT.
  logic [N-1:0] m_grant [2];
  int           m_rr    [2];
  bit           m_err   [2];
  bit           m_bad   [2];
  int           m_hold  [2][N];
  bit           m_werr  [2];
  int           m_widx  [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_grant[d] = '0;
      m_rr[d]    = 0;
      m_err[d]   = 1'b0;
      m_werr[d]  = 1'b0;
      m_widx[d]  = 0;
      for (int i = 0; i < N; i++) m_hold[d][i] = 0;
    end
  endtask

  // One clock edge of the arbitration rules.
  task automatic model_step(input int d, input logic [N-1:0] req, input lc_tx_t lc,
                            input int maxa, input int mh);
    logic [N-1:0] old_g;
    logic [N-1:0] nxt;
    int prev;
    old_g = m_grant[d];
    if (m_err[d] || m_bad[d] || (lc != Off)) begin
      m_err[d] = 1'b1;
      nxt = '0;
    end else begin
      nxt = old_g & req;
      if (($countones(nxt) < maxa) && !m_werr[d]) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_rr[d] + k) % N;
          if (req[j] && !old_g[j]) begin
            nxt[j]  = 1'b1;
            m_rr[d] = (j + 1) % N;
            break;
          end
        end
      end
    end
    if (WdogOn) begin
      for (int i = 0; i < N; i++) begin
        prev = m_hold[d][i];
        if (old_g[i]) begin
          if (m_hold[d][i] < mh) m_hold[d][i]++;
        end else begin
          m_hold[d][i] = 0;
        end
        if (!m_werr[d] && (prev != mh) && (m_hold[d][i] == mh)) begin
          m_werr[d] = 1'b1;
          m_widx[d] = i;
        end
      end
    end
    m_grant[d] = nxt;
  endtask

  task automatic check_all();
    chk("a_ack",  run_a.ack, m_grant[0]);
    chk("a_cnt",  cnt_a,     $countones(m_grant[0]));
    chk("a_busy", busy_a,    !m_err[0] && (m_grant[0] != '0));
    chk("a_ferr", ferr_a,    m_err[0]);
    chk("a_werr", werr_a,    m_werr[0]);
    chk("a_widx", widx_a,    m_widx[0]);
    chk("b_ack",  run_b.ack, m_grant[1]);
    chk("b_cnt",  cnt_b,     $countones(m_grant[1]));
    chk("b_busy", busy_b,    !m_err[1] && (m_grant[1] != '0));
    chk("b_ferr", ferr_b,    m_err[1]);
    chk("b_werr", werr_b,    m_werr[1]);
    chk("b_widx", widx_b,    m_widx[1]);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      if (!rst) begin
        model_step(0, run_a.req, lc_a, 1, MhA);
        model_step(1, run_b.req, lc_b, 2, MhB);
      end
      @(negedge clk);
      check_all();
    end
  endtask

  function automatic logic [N-1:0] rnd_req(input logic [N-1:0] cur, input logic [N-1:0] g);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) begin
      if (g[i])        r[i] = ($urandom_range(3) != 0);
      else if (cur[i]) r[i] = ($urandom_range(7) != 0);
      else             r[i] = ($urandom_range(2) == 0);
    end
    return r;
  endfunction

  initial begin
    run_a.req = '0;
    run_b.req = '0;
    m_bad[0]  = 1'b0;
    m_bad[1]  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // Round robin with one slot; dut_b shows two slots with bit 2 waiting.
    run_a.req = 4'b1111; run_b.req = 4'b0111; step(1);
    chk("dir_a_first", run_a.ack, 4'b0001);
    chk("dir_b_first", run_b.ack, 4'b0001);
    run_a.req = 4'b1110; step(1);
    chk("dir_a_rr1", run_a.ack, 4'b0010);
    chk("dir_b_two", run_b.ack, 4'b0011);
    run_a.req = 4'b1100; step(1);
    chk("dir_a_rr2", run_a.ack, 4'b0100);
    chk("dir_b_wait", run_b.ack, 4'b0011);
    run_a.req = 4'b1000; run_b.req = 4'b0110; step(1);
    chk("dir_a_rr3", run_a.ack, 4'b1000);
    chk("dir_b_reuse", run_b.ack, 4'b0110);
    run_a.req = 4'b0001; run_b.req = 4'b0000; step(1);
    chk("dir_a_wrap", run_a.ack, 4'b0001);
    chk("dir_b_idle", busy_b, 1'b0);

    // One-cycle pulse on bit 2 while dut_a's only slot is taken.
    run_a.req = 4'b0101; step(1);
    run_a.req = 4'b0001; step(3);
    chk("pulse_dropped", run_a.ack, 4'b0001);
    run_a.req = 4'b0000; step(1);

    // Random traffic.
    for (int c = 0; c < 300; c++) begin
      run_a.req = rnd_req(run_a.req, m_grant[0]);
      run_b.req = rnd_req(run_b.req, m_grant[1]);
      step(1);
    end

    // Asynchronous reset between edges.
    run_a.req = 4'b1111; run_b.req = 4'b1111; step(2);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_a_ack", run_a.ack, 4'b0000);
    chk("rst_b_ack", run_b.ack, 4'b0000);
    check_all();
    run_a.req = '0; run_b.req = '0;
    @(negedge clk);
    rst = 1'b0;
    step(1);

`ifdef OT_KECCAK_RUN_ARB_WDOG_EN
    run_a.req = 4'b1000; step(8);
    chk("wdog_not_yet", werr_a, 1'b0);
    step(1);
    chk("wdog_err", werr_a, 1'b1);
    chk("wdog_idx", widx_a, 2'd3);
    run_a.req = 4'b1010; step(2);
    chk("wdog_keep", run_a.ack, 4'b1000);
    run_a.req = '0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1);
`endif

    // Escalation while ack_a = 0010.
    run_a.req = 4'b0010; step(1);
    chk("esc_pre", run_a.ack, 4'b0010);
    lc_a = On; step(1);
    chk("esc_ack", run_a.ack, 4'b0000);
    chk("esc_ferr", ferr_a, 1'b1);
    lc_a = Off; run_a.req = 4'b1111; step(3);
    chk("esc_sticky_ack", run_a.ack, 4'b0000);
    chk("esc_sticky_ferr", ferr_a, 1'b1);

    // Illegal state encoding on dut_b.
    run_b.req = 4'b0011; step(2);
    chk("bad_pre", run_b.ack, 4'b0011);
    force dut_b.state_q = arb_st_e'(6'b111111);
    m_bad[1] = 1'b1;
    step(1);
    release dut_b.state_q;
    m_bad[1] = 1'b0;
    step(2);
    chk("bad_ack", run_b.ack, 4'b0000);
    chk("bad_ferr", ferr_b, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
